// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - PC-indexed saturating-counter branch predictor with ID-stage resolve
// Predicts beq/bne in IF, resolves beq/bne/j in ID, and trains the counter table one edge later.
module branch_predictor_bht #(
  parameter int INDEX_BITS   = 4,
  parameter int CTR_BITS     = 2,
  parameter int PC_WIDTH     = 32,
  parameter int STAT_WIDTH   = 16,
  parameter int PREDICT_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pcF,
  input  logic [5:0]            opCodeF,
  output logic                  predTakenF,
  input  logic                  validD,
  input  logic                  stallD,
  input  logic [PC_WIDTH-1:0]   pcD,
  input  logic [5:0]            opCodeD,
  input  logic                  predTakenD,
  input  logic                  compResult,
  output logic                  PCSrcS,
  output logic                  restoreS,
  output logic                  FlushS,
  output logic                  jumpS,
  output logic [STAT_WIDTH-1:0] branchCount,
  output logic [STAT_WIDTH-1:0] mispredCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [CTR_BITS-1:0]   CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_d [ENTRIES];
  logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [STAT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [INDEX_BITS-1:0] idx_f, idx_d;
  logic                  br_f, br_d, jump_d, resolve, actual, mis;
  logic [CTR_BITS-1:0]   ctr_cur;

  // Only the word-aligned index bits address the table; everything else aliases.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcF[1:0], pcF[PC_WIDTH-1:INDEX_BITS+2],
                            pcD[1:0], pcD[PC_WIDTH-1:INDEX_BITS+2]};

  assign idx_f = pcF[INDEX_BITS+1:2];
  assign idx_d = pcD[INDEX_BITS+1:2];

  always_comb begin
    br_f       = (opCodeF == OP_BEQ) || (opCodeF == OP_BNE);
    predTakenF = (PREDICT_MODE != 0) && !rst && br_f && ctr_q[idx_f][CTR_BITS-1];
  end

  always_comb begin
    resolve  = validD && !stallD && !rst;
    br_d     = (opCodeD == OP_BEQ) || (opCodeD == OP_BNE);
    jump_d   = (opCodeD == OP_J);
    actual   = (opCodeD == OP_BNE) ? !compResult : compResult;
    mis      = actual ^ predTakenD;
    PCSrcS   = resolve && br_d && actual && !predTakenD;
    restoreS = resolve && br_d && !actual && predTakenD;
    jumpS    = resolve && jump_d;
    FlushS   = PCSrcS || restoreS || jumpS;
  end

  always_comb begin
    ctr_d   = ctr_q;
    ctr_cur = ctr_q[idx_d];
    if ((PREDICT_MODE != 0) && resolve && br_d) begin
      if (actual) begin
        if (ctr_cur != CTR_MAX) ctr_d[idx_d] = ctr_cur + CTR_ONE;
      end else begin
        if (ctr_cur != '0) ctr_d[idx_d] = ctr_cur - CTR_ONE;
      end
    end
  end

  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (resolve && br_d) begin
      if (branch_count_q != STAT_MAX) branch_count_d = branch_count_q + STAT_ONE;
      if (mis && (mispred_count_q != STAT_MAX)) mispred_count_d = mispred_count_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      ctr_q           <= ctr_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign branchCount  = branch_count_q;
  assign mispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
// Instance dut uses defaults; dut0 is static not-taken with 2-bit statistics.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF, pcD;
  logic [5:0]  opCodeF, opCodeD;
  logic        validD, stallD, predTakenD, compResult;

  logic        predTakenF, PCSrcS, restoreS, FlushS, jumpS;
  logic [15:0] branchCount, mispredCount;
  logic        predTakenF0, PCSrcS0, restoreS0, FlushS0, jumpS0;
  logic [1:0]  branchCount0, mispredCount0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .pcF(pcF), .opCodeF(opCodeF), .predTakenF(predTakenF),
    .validD(validD), .stallD(stallD), .pcD(pcD), .opCodeD(opCodeD),
    .predTakenD(predTakenD), .compResult(compResult),
    .PCSrcS(PCSrcS), .restoreS(restoreS), .FlushS(FlushS), .jumpS(jumpS),
    .branchCount(branchCount), .mispredCount(mispredCount)
  );

  branch_predictor_bht #(.STAT_WIDTH(2), .PREDICT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pcF(pcF), .opCodeF(opCodeF), .predTakenF(predTakenF0),
    .validD(validD), .stallD(stallD), .pcD(pcD), .opCodeD(opCodeD),
    .predTakenD(predTakenD), .compResult(compResult),
    .PCSrcS(PCSrcS0), .restoreS(restoreS0), .FlushS(FlushS0), .jumpS(jumpS0),
    .branchCount(branchCount0), .mispredCount(mispredCount0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic id_op(input logic [5:0] op, input logic [31:0] pc, input logic pred,
                       input logic comp);
    validD = 1'b1; stallD = 1'b0; opCodeD = op; pcD = pc; predTakenD = pred; compResult = comp;
  endtask

  task automatic id_idle();
    validD = 1'b0; stallD = 1'b0; opCodeD = 6'd0; predTakenD = 1'b0; compResult = 1'b0;
  endtask

  task automatic chk_id(input string tag, input logic pcs, input logic rs, input logic fl,
                        input logic jp);
    chk({tag, ".PCSrcS"}, {31'd0, PCSrcS}, {31'd0, pcs});
    chk({tag, ".restoreS"}, {31'd0, restoreS}, {31'd0, rs});
    chk({tag, ".FlushS"}, {31'd0, FlushS}, {31'd0, fl});
    chk({tag, ".jumpS"}, {31'd0, jumpS}, {31'd0, jp});
  endtask

  initial begin
    rst = 1'b1; pcF = 32'h40; opCodeF = 6'd4; pcD = 32'h0;
    id_idle();
    tick(); tick();

    // 1: reset state and forced-zero outputs while rst is high
    id_op(6'd4, 32'h40, 1'b0, 1'b1);
    settle();
    chk("rst.predTakenF", {31'd0, predTakenF}, 32'd0);
    chk_id("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    id_idle();
    settle();
    chk("t1.predTakenF", {31'd0, predTakenF}, 32'd0);
    chk("t1.branchCount", {16'd0, branchCount}, 32'd0);
    chk("t1.mispredCount", {16'd0, mispredCount}, 32'd0);

    // 2: taken beq predicted not-taken at 0x40
    id_op(6'd4, 32'h40, 1'b0, 1'b1);
    settle();
    chk_id("t2", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    id_idle();
    settle();
    chk("t2.predTakenF", {31'd0, predTakenF}, 32'd1);
    chk("t2.branchCount", {16'd0, branchCount}, 32'd1);
    chk("t2.mispredCount", {16'd0, mispredCount}, 32'd1);

    // 3: train to saturation, then mispredicted not-taken bne
    for (int i = 0; i < 4; i++) begin
      id_op(6'd4, 32'h40, 1'b1, 1'b1);
      settle();
      if (i == 0) chk_id("t3.correct", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    id_op(6'd5, 32'h40, 1'b1, 1'b1);
    settle();
    chk_id("t3.bne", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_idle();
    settle();
    chk("t3.predTakenF", {31'd0, predTakenF}, 32'd1);
    pcF = 32'h80;
    settle();
    chk("t3.alias", {31'd0, predTakenF}, 32'd1);
    opCodeF = 6'd0;
    settle();
    chk("t3.nonbranch", {31'd0, predTakenF}, 32'd0);
    opCodeF = 6'd4; pcF = 32'h40;
    chk("t3.branchCount", {16'd0, branchCount}, 32'd6);
    chk("t3.mispredCount", {16'd0, mispredCount}, 32'd2);

    // 4: jump, then stalled and bubble branches with no side effects
    id_op(6'd2, 32'h44, 1'b0, 1'b0);
    settle();
    chk_id("t4.jump", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    id_op(6'd4, 32'h40, 1'b1, 1'b0);
    stallD = 1'b1;
    settle();
    chk_id("t4.stall", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    stallD = 1'b0; validD = 1'b0;
    settle();
    chk_id("t4.bubble", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    id_idle();
    settle();
    chk("t4.branchCount", {16'd0, branchCount}, 32'd6);
    chk("t4.mispredCount", {16'd0, mispredCount}, 32'd2);
    chk("t4.predTakenF", {31'd0, predTakenF}, 32'd1);

    // 5: same-cycle read of an index being trained, then reset beating an update
    id_op(6'd4, 32'h40, 1'b1, 1'b0);
    settle();
    chk("t5.old", {31'd0, predTakenF}, 32'd1);
    tick();
    id_idle();
    settle();
    chk("t5.new", {31'd0, predTakenF}, 32'd0);
    id_op(6'd4, 32'h40, 1'b0, 1'b1);
    rst = 1'b1;
    settle();
    chk("t5.rst.PCSrcS", {31'd0, PCSrcS}, 32'd0);
    tick();
    rst = 1'b0;
    id_idle();
    settle();
    chk("t5.after_rst", {31'd0, predTakenF}, 32'd0);
    chk("t5.branchCount", {16'd0, branchCount}, 32'd0);
    id_op(6'd4, 32'h40, 1'b0, 1'b1);
    tick();
    id_idle();
    settle();
    chk("t5.ctr_is_1", {31'd0, predTakenF}, 32'd1);

    // 6: static mode and 2-bit statistic saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id_op(6'd4, 32'h40, 1'b0, 1'b1);
      settle();
      chk("t6.PCSrcS0", {31'd0, PCSrcS0}, 32'd1);
      chk("t6.predTakenF0", {31'd0, predTakenF0}, 32'd0);
      tick();
      if (i == 2) chk("t6.branchCount0_3", {30'd0, branchCount0}, 32'd3);
    end
    id_idle();
    settle();
    chk("t6.branchCount0_sat", {30'd0, branchCount0}, 32'd3);
    chk("t6.mispredCount0_sat", {30'd0, mispredCount0}, 32'd3);
    chk("t6.branchCount", {16'd0, branchCount}, 32'd5);
    chk("t6.mispredCount", {16'd0, mispredCount}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
